// File: rtl/hazard_stall_unit.sv
// Hazard controller for the 5-stage MIPS pipeline: load-use and HI/LO-busy stalls, taken-branch squash.
// Optional build macro HAZARD_STATS_EN adds saturating stall/flush cycle counters.
module hazard_stall_unit #(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] IFIDRs,
  input  logic [4:0] IFIDRt,
  input  logic       IFID_UsesRt,
  input  logic       IFID_MduUse,
  input  logic [4:0] IDEXRt,
  input  logic       IDEX_MemRead,
  input  logic       IDEX_MduStart,
  input  logic       EX_BranchTaken,
  output logic       PCWrite,
  output logic       IFIDWrite,
  output logic       IFIDFlush,
  output logic       IDEXFlush,
  output logic       MduBusy
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount
`endif
);

  typedef enum logic {RUN, BUSY} state_t;

  localparam logic [CNT_W-1:0] LoadVal = CNT_W'(MDU_LAT - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_lu, w_mh, w_stall_cyc, w_flush_cyc;

  assign w_lu = IDEX_MemRead && (IDEXRt != 5'd0) &&
                ((IDEXRt == IFIDRs) || (IFID_UsesRt && (IDEXRt == IFIDRt)));
  assign w_mh = IFID_MduUse && ((r_state == BUSY) || IDEX_MduStart);

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      RUN: begin
        if (IDEX_MduStart) begin
          w_state_nxt = BUSY;
          w_cnt_nxt   = LoadVal;
        end
      end
      BUSY: begin
        // A restart while busy should never happen since MH blocks issue; reload anyway.
        if (IDEX_MduStart) begin
          w_cnt_nxt = LoadVal;
        end else if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = RUN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    PCWrite     = 1'b1;
    IFIDWrite   = 1'b1;
    IFIDFlush   = 1'b0;
    IDEXFlush   = 1'b0;
    MduBusy     = (r_state == BUSY);
    w_stall_cyc = 1'b0;
    w_flush_cyc = 1'b0;
    if (reset) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IFIDFlush = 1'b1;
      IDEXFlush = 1'b1;
      MduBusy   = 1'b0;
    end else if (EX_BranchTaken) begin
      // The ID instruction is wrong-path, so any stall it would cause is moot.
      IFIDFlush   = 1'b1;
      IDEXFlush   = 1'b1;
      w_flush_cyc = 1'b1;
    end else if (w_lu || w_mh) begin
      PCWrite     = 1'b0;
      IFIDWrite   = 1'b0;
      IDEXFlush   = 1'b1;
      w_stall_cyc = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_cyc && (r_stall_cnt != 32'hFFFF_FFFF)) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_flush_cyc && (r_flush_cnt != 32'hFFFF_FFFF)) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign StallCount = r_stall_cnt;
  assign FlushCount = r_flush_cnt;
`else
  logic w_unused;
  assign w_unused = w_stall_cyc ^ w_flush_cyc;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: directed scenarios plus randomized traffic vs. a cycle-count model.
module tb_hazard_stall_unit;

  localparam int MDU_LAT = 4;
  localparam int CNT_W   = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] IFIDRs, IFIDRt, IDEXRt;
  logic       IFID_UsesRt, IFID_MduUse, IDEX_MemRead, IDEX_MduStart, EX_BranchTaken;
  logic       PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, MduBusy;
`ifdef HAZARD_STATS_EN
  logic [31:0] StallCount, FlushCount;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Model: number of MDU-busy cycles still to come, plus expected statistics.
  int          mdu_rem = 0;
  logic [31:0] exp_stall = '0;
  logic [31:0] exp_flush = '0;

  always #5 clk = ~clk;

  hazard_stall_unit #(.MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .IFIDRs(IFIDRs), .IFIDRt(IFIDRt), .IFID_UsesRt(IFID_UsesRt), .IFID_MduUse(IFID_MduUse),
    .IDEXRt(IDEXRt), .IDEX_MemRead(IDEX_MemRead), .IDEX_MduStart(IDEX_MduStart),
    .EX_BranchTaken(EX_BranchTaken),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush),
    .MduBusy(MduBusy)
`ifdef HAZARD_STATS_EN
    , .StallCount(StallCount), .FlushCount(FlushCount)
`endif
  );

  function automatic logic [4:0] observed();
    return {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, MduBusy};
  endfunction

  function automatic logic model_lu();
    return IDEX_MemRead && IDEXRt != 0 &&
           (IDEXRt == IFIDRs || (IFID_UsesRt && IDEXRt == IFIDRt));
  endfunction

  function automatic logic model_mh();
    return IFID_MduUse && (mdu_rem > 0 || IDEX_MduStart);
  endfunction

  // Expected {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, MduBusy} from the priority rules.
  function automatic logic [4:0] model_out();
    logic busy;
    busy = (mdu_rem > 0);
    if (reset)                       return 5'b00110;
    if (EX_BranchTaken)              return {4'b1111, busy};
    if (model_lu() || model_mh())    return {4'b0001, busy};
    return {4'b1100, busy};
  endfunction

  task automatic drive_idle();
    reset = 1'b0; IFIDRs = '0; IFIDRt = '0; IDEXRt = '0;
    IFID_UsesRt = 1'b0; IFID_MduUse = 1'b0; IDEX_MemRead = 1'b0;
    IDEX_MduStart = 1'b0; EX_BranchTaken = 1'b0;
  endtask

  // Advance one clock; the model follows the same edge using the inputs held across it.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      mdu_rem = 0; exp_stall = '0; exp_flush = '0;
    end else begin
      if (EX_BranchTaken) begin
        if (exp_flush != 32'hFFFF_FFFF) exp_flush = exp_flush + 1;
      end else if (model_lu() || model_mh()) begin
        if (exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 1;
      end
      if (IDEX_MduStart) mdu_rem = MDU_LAT - 1;
      else if (mdu_rem > 0) mdu_rem = mdu_rem - 1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    drive_idle(); reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1; obs = observed(); n_checks++;
      if (obs !== 5'b00110) begin n_fail++; $display("FAIL reset_init got=%b exp=%b", obs, 5'b00110); end
      tick();
    end
    drive_idle(); IDEX_MduStart = 1'b1; tick();
    drive_idle(); #1; obs = observed(); n_checks++;
    if (obs !== 5'b11001) begin n_fail++; $display("FAIL reset_pre_busy got=%b exp=%b", obs, 5'b11001); end
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1; obs = observed(); n_checks++;
      if (obs !== 5'b00110) begin n_fail++; $display("FAIL reset_mid_busy cyc=%0d got=%b exp=%b", i, obs, 5'b00110); end
      tick();
    end
    drive_idle(); #1; obs = observed(); n_checks++;
    if (obs !== 5'b11000) begin n_fail++; $display("FAIL reset_exit got=%b exp=%b", obs, 5'b11000); end
    tick();
  endtask

  task automatic test_load_use();
    logic [4:0] obs;
    drive_idle(); IDEX_MemRead = 1'b1; IDEXRt = 5'd8; IFIDRs = 5'd8;
    #1; obs = observed(); n_checks++;
    if (obs !== 5'b00010) begin n_fail++; $display("FAIL load_use_stall got=%b exp=%b", obs, 5'b00010); end
    tick();
    IDEX_MemRead = 1'b0;
    #1; obs = observed(); n_checks++;
    if (obs !== 5'b11000) begin n_fail++; $display("FAIL load_use_release got=%b exp=%b", obs, 5'b11000); end
    tick();
  endtask

  task automatic test_zero_and_unused_rt();
    logic [4:0] obs;
    drive_idle(); IDEX_MemRead = 1'b1; IDEXRt = 5'd0; IFIDRs = 5'd0; IFIDRt = 5'd0; IFID_UsesRt = 1'b1;
    #1; obs = observed(); n_checks++;
    if (obs !== 5'b11000) begin n_fail++; $display("FAIL load_zero got=%b exp=%b", obs, 5'b11000); end
    tick();
    drive_idle(); IDEX_MemRead = 1'b1; IDEXRt = 5'd9; IFIDRt = 5'd9; IFIDRs = 5'd3; IFID_UsesRt = 1'b0;
    #1; obs = observed(); n_checks++;
    if (obs !== 5'b11000) begin n_fail++; $display("FAIL rt_unused got=%b exp=%b", obs, 5'b11000); end
    tick();
  endtask

  task automatic test_mdu_busy();
    logic [4:0] obs;
    drive_idle(); IDEX_MduStart = 1'b1; IFID_MduUse = 1'b1;
    #1; obs = observed(); n_checks++;
    if (obs !== 5'b00010) begin n_fail++; $display("FAIL mdu_T got=%b exp=%b", obs, 5'b00010); end
    tick();
    IDEX_MduStart = 1'b0;
    for (int k = 1; k < MDU_LAT; k++) begin
      #1; obs = observed(); n_checks++;
      if (obs !== 5'b00011) begin n_fail++; $display("FAIL mdu_busy T+%0d got=%b exp=%b", k, obs, 5'b00011); end
      tick();
    end
    #1; obs = observed(); n_checks++;
    if (obs !== 5'b11000) begin n_fail++; $display("FAIL mdu_done T+%0d got=%b exp=%b", MDU_LAT, obs, 5'b11000); end
    drive_idle(); tick();
  endtask

  task automatic test_branch_priority();
    logic [4:0] obs;
    drive_idle(); IDEX_MduStart = 1'b1; tick();
    drive_idle(); EX_BranchTaken = 1'b1; IDEX_MemRead = 1'b1; IDEXRt = 5'd5; IFIDRs = 5'd5; IFID_MduUse = 1'b1;
    #1; obs = observed(); n_checks++;
    if (obs !== 5'b11111) begin n_fail++; $display("FAIL branch_over_stall got=%b exp=%b", obs, 5'b11111); end
    tick();
    drive_idle();
    for (int k = 2; k < MDU_LAT; k++) begin
      #1; obs = observed(); n_checks++;
      if (obs !== 5'b11001) begin n_fail++; $display("FAIL branch_busy_keeps k=%0d got=%b exp=%b", k, obs, 5'b11001); end
      tick();
    end
    #1; obs = observed(); n_checks++;
    if (obs !== 5'b11000) begin n_fail++; $display("FAIL branch_busy_ends got=%b exp=%b", obs, 5'b11000); end
    tick();
  endtask

  task automatic test_stats_sequence();
`ifdef HAZARD_STATS_EN
    n_checks++;
    if (StallCount !== 32'(1 + MDU_LAT)) begin n_fail++; $display("FAIL stall_count got=%0d exp=%0d", StallCount, 1 + MDU_LAT); end
    n_checks++;
    if (FlushCount !== 32'd1) begin n_fail++; $display("FAIL flush_count got=%0d exp=1", FlushCount); end
`endif
  endtask

  task automatic test_random();
    logic [4:0] obs, exp;
    for (int i = 0; i < 400; i++) begin
      drive_idle();
      reset          = ($urandom_range(0, 39) == 0);
      IFIDRs         = 5'($urandom_range(0, 3));
      IFIDRt         = 5'($urandom_range(0, 3));
      IDEXRt         = 5'($urandom_range(0, 3));
      IFID_UsesRt    = 1'($urandom_range(0, 1));
      IFID_MduUse    = ($urandom_range(0, 2) == 0);
      IDEX_MemRead   = ($urandom_range(0, 2) == 0);
      IDEX_MduStart  = ($urandom_range(0, 7) == 0);
      EX_BranchTaken = !IDEX_MduStart && ($urandom_range(0, 7) == 0);
      #1; obs = observed(); exp = model_out(); n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL random cyc=%0d got=%b exp=%b", i, obs, exp); end
      tick();
    end
    drive_idle();
`ifdef HAZARD_STATS_EN
    #1; n_checks++;
    if (StallCount !== exp_stall || FlushCount !== exp_flush) begin
      n_fail++; $display("FAIL random_stats got=%0d/%0d exp=%0d/%0d", StallCount, FlushCount, exp_stall, exp_flush);
    end
`endif
  endtask

  task automatic test_saturation();
`ifdef HAZARD_STATS_EN
    drive_idle(); mdu_rem = 0; reset = 1'b1; tick();
    drive_idle();
    dut.r_stall_cnt = 32'hFFFF_FFFE; dut.r_flush_cnt = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      drive_idle(); EX_BranchTaken = 1'b1; tick();
      drive_idle(); IDEX_MemRead = 1'b1; IDEXRt = 5'd7; IFIDRs = 5'd7; tick();
    end
    drive_idle(); #1; n_checks++;
    if (StallCount !== 32'hFFFF_FFFF || FlushCount !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL saturation got=%h/%h exp=ffffffff/ffffffff", StallCount, FlushCount);
    end
`endif
  endtask

  initial begin
    drive_idle();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_zero_and_unused_rt();
    test_mdu_busy();
    test_branch_priority();
    test_stats_sequence();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
